// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: one word request at a time, fixed LAT-cycle service, one-cycle response pulse.
// Optional address checking is enabled by defining MEM_RESPONDER_ADDR_CHECK_EN.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LAT         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             addr_err;
  logic             mem_we;

  // Low index bits only: out-of-range words wrap when checking is disabled.
  assign idx = addr_q[IDX_W+1:2];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:IDX_W+2] != '0);
`else
  logic addr_unused;
  assign addr_err    = 1'b0;
  assign addr_unused = ^{addr_q[31:IDX_W+2], addr_q[1:0]};
`endif

  assign req_ready  = reset && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = addr_err;
          resp_rdata_d = '0;
          if (!addr_err) begin
            if (write_q) mem_we = 1'b1;
            else         resp_rdata_d = mem[idx];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Array is intentionally not reset; writes only happen from BUSY, which reset clears.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the MIPS datapath: the memory-side end of the CPU load/store interface. It accepts one word read or write request at a time through a valid/ready handshake, services it against an internal word array after a fixed programmable latency, and returns a single-cycle response pulse carrying read data and an error flag. It replaces the zero-wait data RAM when multi-cycle memory behaviour is needed.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two, 4..65536.
- LAT, 2: wait cycles between acceptance and response; range 1..15.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; held with its fields stable until accepted.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_ready  output  1  responder can accept this cycle.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  read data; 0 for writes and errored requests.
- resp_err  output  1  request rejected (misaligned or out of range).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, latch write/addr/wdata, load the wait counter with LAT-1, and go to BUSY.
- BUSY: req_ready=0. Decrement the counter each edge. On the edge where the counter is 0, commit the access and go to RESP:
  - write: array[addr[31:2]] <= wdata, resp_rdata <= 0;
  - read: resp_rdata <= array[addr[31:2]];
  - resp_valid <= 1, resp_err set per the error rules below.
- RESP: resp_valid=1 for exactly this cycle and req_ready=0. The next edge clears resp_valid and returns to IDLE.
- resp_rdata and resp_err hold their values until the next commit. They are meaningful only while resp_valid=1.
- Error rules (macro enabled): addr[1:0]≠0, or addr[31:2] ≥ DEPTH_WORDS, gives resp_err=1, resp_rdata=0, and no array write.
- req_valid in BUSY/RESP is ignored. There is no queuing. The requester must hold the request.
- The array is not reset. Contents are undefined until written.

## Timing
- Acceptance at edge E0 (IDLE, req_valid=1).
- Commit at edge E0+LAT; resp_valid is high from E0+LAT to E0+LAT+1.
- req_ready returns high after edge E0+LAT+1. The earliest next acceptance is at E0+LAT+2.
- Throughput: one request per LAT+2 cycles.
- A write is visible to a read accepted on any later edge. Read-after-write to the same word returns the new data.
- req_ready is combinational from state and reset (no input-to-output path). All other outputs are registered.
- Reset asserted (reset=0), async:
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0;
  - req_ready=0 while reset=0, and 1 from the first cycle after release.
- Reset mid-operation: the pending request is dropped. If asserted before the commit edge, no array write occurs and no response is issued.

## Configuration
- MEM_RESPONDER_ADDR_CHECK_EN defined:
  - error rules active, as above.
- MEM_RESPONDER_ADDR_CHECK_EN undefined:
  - no checking; resp_err tied to 0;
  - addr[1:0] ignored (access is word-aligned);
  - word index = addr[31:2] modulo DEPTH_WORDS (wrap-around);
  - all handshake and timing unchanged.

## Test plan
All scenarios use LAT=2 and DEPTH_WORDS=256.
- Write 0xDEADBEEF to addr 0x10 accepted at edge 0, then read 0x10 -> write resp_valid at cycle 2 with rdata=0, err=0; read returns 0xDEADBEEF exactly 2 cycles after its acceptance.
- Hold req_valid=1 continuously with 3 back-to-back reads -> acceptances spaced exactly 4 cycles apart; req_ready=0 in BUSY/RESP; exactly 3 resp_valid pulses.
- Read addr 0x12, then write to 0x400 (macro on) -> resp_err=1 and rdata=0 for both; a read of word 0 afterwards is unchanged.
- Macro off: write 0x1234 to 0x400, then read 0x0 -> 0x1234 (wrap), err=0. Read 0x3 -> same word as 0x0.
- Assert reset one cycle after accepting a write of 0xCAFEF00D to 0x20 (a location previously written with 0x11111111), then release and read 0x20 -> no response pulse for the aborted write; all outputs 0 during reset; read returns 0x11111111.
- Change req_addr while req_ready=0 -> no effect on the in-flight transaction's address or data.
